branch_ckpt_table: RTL and testbench

//  Branch checkpoint table: the partner end of the free list's checkpoint interface.

---
 rtl/branch_ckpt_table_pkg.sv | 21 ++
 rtl/branch_ckpt_table_if.sv | 36 +++
 rtl/branch_ckpt_table.sv | 115 +++++++++++
 tb/tb_branch_ckpt_table.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_ckpt_table_pkg.sv
// Shared types and sizing for the branch checkpoint table.
// CKPT_DEPTH entries of {valid, resolved, fl_ptr, rob_idx}; head/tail pointers
// carry one extra wrap bit so full and empty can be told apart.
package branch_ckpt_table_pkg;
   localparam int CKPT_DEPTH    = 4;
   localparam int CKPT_ID_W     = $clog2(CKPT_DEPTH);
   localparam int FL_PTR_WIDTH  = 6;
   localparam int ROB_IDX_WIDTH = 5;

   typedef logic [CKPT_ID_W-1:0]     ckpt_id_t;
   typedef logic [CKPT_ID_W:0]       ckpt_ptr_t;
   typedef logic [FL_PTR_WIDTH:0]    fl_ptr_t;
   typedef logic [ROB_IDX_WIDTH-1:0] rob_idx_t;

   typedef struct packed {
      logic     valid;
      logic     resolved;
      fl_ptr_t  fl_ptr;
      rob_idx_t rob_idx;
   } ckpt_entry_t;
endpackage

// File: rtl/branch_ckpt_table_if.sv
// Bundle of the checkpoint table's dispatch, branch-unit and free-list signals.
// master: dispatch/branch-unit side (drives alloc/resolve/rob_flush).
// slave : the checkpoint table (drives ready/id/restore/count/perf outputs).
interface branch_ckpt_table_if;
   import branch_ckpt_table_pkg::*;

   logic        alloc_valid;
   logic        alloc_ready;
   fl_ptr_t     alloc_fl_ptr;
   rob_idx_t    alloc_rob_idx;
   ckpt_id_t    alloc_id;
   logic        resolve_valid;
   ckpt_id_t    resolve_id;
   logic        resolve_mispredict;
   logic        rob_flush;
   logic        flush_by_branch;
   fl_ptr_t     free_list_rd_ptr_out;
   rob_idx_t    flush_rob_idx;
   ckpt_ptr_t   ckpt_count;
   logic [31:0] perf_mispredicts;
   logic [31:0] perf_full_stalls;

   modport master (
      output alloc_valid, alloc_fl_ptr, alloc_rob_idx,
             resolve_valid, resolve_id, resolve_mispredict, rob_flush,
      input  alloc_ready, alloc_id, flush_by_branch, free_list_rd_ptr_out,
             flush_rob_idx, ckpt_count, perf_mispredicts, perf_full_stalls
   );

   modport slave (
      input  alloc_valid, alloc_fl_ptr, alloc_rob_idx,
             resolve_valid, resolve_id, resolve_mispredict, rob_flush,
      output alloc_ready, alloc_id, flush_by_branch, free_list_rd_ptr_out,
             flush_rob_idx, ckpt_count, perf_mispredicts, perf_full_stalls
   );
endinterface

// File: rtl/branch_ckpt_table.sv
// Branch checkpoint table. Snapshots the free-list read pointer for each
// dispatched branch, retires entries in order once resolved, and on a
// mispredict hands the snapshot back with a one-cycle flush_by_branch pulse.
// Ports: clk, rst_n (async active-low), bus (branch_ckpt_table_if.slave).
// Optional macro BRAT_PERF_EN builds saturating mispredict / full-stall
// counters; otherwise both perf outputs are tied to 0.
module branch_ckpt_table
   import branch_ckpt_table_pkg::*;
(
   input logic                 clk,
   input logic                 rst_n,
   branch_ckpt_table_if.slave  bus
);

   ckpt_entry_t entries [CKPT_DEPTH];
   ckpt_ptr_t   head, tail, count;
   ckpt_id_t    head_idx, tail_idx, mis_dist;
   ckpt_id_t    age [CKPT_DEPTH];
   logic        flush_q;
   fl_ptr_t     flush_fl_q;
   rob_idx_t    flush_rob_q;
   logic        res_hit, mis, good_res, pop, alloc_fire;

   assign head_idx = head[CKPT_ID_W-1:0];
   assign tail_idx = tail[CKPT_ID_W-1:0];
   assign count    = tail - head;

   // Registered count only: a pop this cycle does not free a slot until next cycle.
   assign bus.alloc_ready = (count != ckpt_ptr_t'(CKPT_DEPTH)) && !flush_q && !bus.rob_flush;
   assign bus.alloc_id    = tail_idx;

   assign res_hit    = bus.resolve_valid && entries[bus.resolve_id].valid;
   assign mis        = res_hit && bus.resolve_mispredict && !bus.rob_flush;
   assign good_res   = res_hit && !bus.resolve_mispredict;
   assign mis_dist   = bus.resolve_id - head_idx;
   // A mispredict on the head itself empties the queue, so no pop on top of it.
   assign pop        = entries[head_idx].valid && entries[head_idx].resolved &&
                       !(mis && (mis_dist == '0));
   // An alloc in the mispredict cycle is younger than the bad branch: drop it.
   assign alloc_fire = bus.alloc_valid && bus.alloc_ready && !mis;

   // Age of each slot relative to the head; slots at or beyond the bad branch die.
   always_comb begin
      for (int i = 0; i < CKPT_DEPTH; i++) age[i] = ckpt_id_t'(i) - head_idx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head        <= '0;
         tail        <= '0;
         flush_q     <= 1'b0;
         flush_fl_q  <= '0;
         flush_rob_q <= '0;
         for (int i = 0; i < CKPT_DEPTH; i++) entries[i] <= '0;
      end else if (bus.rob_flush) begin
         head    <= '0;
         tail    <= '0;
         flush_q <= 1'b0;
         for (int i = 0; i < CKPT_DEPTH; i++) entries[i] <= '0;
      end else begin
         flush_q <= mis;
         if (mis) begin
            flush_fl_q  <= entries[bus.resolve_id].fl_ptr;
            flush_rob_q <= entries[bus.resolve_id].rob_idx;
            tail        <= head + {1'b0, mis_dist};
         end else if (alloc_fire) begin
            tail <= tail + ckpt_ptr_t'(1);
         end
         if (pop) head <= head + ckpt_ptr_t'(1);
         for (int i = 0; i < CKPT_DEPTH; i++) begin
            if (good_res && (bus.resolve_id == ckpt_id_t'(i)))
               entries[i].resolved <= 1'b1;
            if ((pop && (head_idx == ckpt_id_t'(i))) || (mis && (age[i] >= mis_dist)))
               entries[i].valid <= 1'b0;
            if (alloc_fire && (tail_idx == ckpt_id_t'(i)))
               entries[i] <= '{valid: 1'b1, resolved: 1'b0,
                               fl_ptr: bus.alloc_fl_ptr, rob_idx: bus.alloc_rob_idx};
         end
      end
   end

   assign bus.flush_by_branch      = flush_q;
   assign bus.free_list_rd_ptr_out = flush_fl_q;
   assign bus.flush_rob_idx        = flush_rob_q;
   assign bus.ckpt_count           = count;

`ifdef BRAT_PERF_EN
   logic [31:0] perf_mis_q, perf_stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_mis_q   <= '0;
         perf_stall_q <= '0;
      end else begin
         if (mis && (perf_mis_q != '1)) perf_mis_q <= perf_mis_q + 32'd1;
         if (bus.alloc_valid && !bus.alloc_ready && (perf_stall_q != '1))
            perf_stall_q <= perf_stall_q + 32'd1;
      end
   end

   assign bus.perf_mispredicts = perf_mis_q;
   assign bus.perf_full_stalls = perf_stall_q;
`else
   assign bus.perf_mispredicts = '0;
   assign bus.perf_full_stalls = '0;
`endif

`ifndef SYNTHESIS
   // The branch unit must only resolve live checkpoints.
   always @(posedge clk) begin
      if (rst_n && bus.resolve_valid) assert (entries[bus.resolve_id].valid);
   end
`endif

endmodule

// File: tb/tb_branch_ckpt_table.sv
// Self-checking bench for branch_ckpt_table: directed scenarios plus a random
// run, all checked against a queue-based model of the checkpoint list.
module tb_branch_ckpt_table;
   import branch_ckpt_table_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   branch_ckpt_table_if bus();
   branch_ckpt_table dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int tests = 0;
   int fails = 0;

   // Model: in-order list of live checkpoints, oldest first.
   typedef struct { int id; int fl; int rob; bit res; } m_ent_t;
   m_ent_t m_q[$];
   int     m_head;
   bit     m_flush;
   int     m_flp, m_frob;
   longint m_mis, m_stall;

   function automatic bit m_ready();
      return (m_q.size() != CKPT_DEPTH) && !m_flush && !bus.rob_flush;
   endfunction
   function automatic int m_alloc_id();
      return (m_head + m_q.size()) % CKPT_DEPTH;
   endfunction
   function automatic longint perf_exp(longint v);
`ifdef BRAT_PERF_EN
      return v;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      m_q.delete(); m_head = 0; m_flush = 0; m_flp = 0; m_frob = 0; m_mis = 0; m_stall = 0;
   endtask

   task automatic idle();
      bus.alloc_valid = 0; bus.alloc_fl_ptr = '0; bus.alloc_rob_idx = '0;
      bus.resolve_valid = 0; bus.resolve_id = '0; bus.resolve_mispredict = 0; bus.rob_flush = 0;
   endtask

   // One clock: capture inputs, advance the model, land 1 time unit after the edge.
   task automatic tick();
      bit av = bus.alloc_valid, rv = bus.resolve_valid, rm = bus.resolve_mispredict, rf = bus.rob_flush;
      int rid = int'(bus.resolve_id), fl = int'(bus.alloc_fl_ptr), rob = int'(bus.alloc_rob_idx);
      bit rdy = m_ready();
      int aid = m_alloc_id();
      int k = -1;
      bit pop;
      if (av && !rdy) m_stall++;
      @(posedge clk);
      if (rf) begin
         m_q.delete(); m_head = 0; m_flush = 0;
      end else begin
         if (rv) foreach (m_q[i]) if (m_q[i].id == rid) k = i;
         pop = (m_q.size() > 0) && m_q[0].res;
         if (k >= 0 && rm) begin
            m_flp = m_q[k].fl; m_frob = m_q[k].rob; m_mis++; m_flush = 1;
            while (m_q.size() > k) void'(m_q.pop_back());
            if (pop && k > 0) begin void'(m_q.pop_front()); m_head = (m_head + 1) % CKPT_DEPTH; end
         end else begin
            m_flush = 0;
            if (k >= 0) m_q[k].res = 1;
            if (pop) begin void'(m_q.pop_front()); m_head = (m_head + 1) % CKPT_DEPTH; end
            if (av && rdy) m_q.push_back('{id: aid, fl: fl, rob: rob, res: 0});
         end
      end
      #1;
   endtask

   task automatic do_alloc(input int fl);
      bus.alloc_valid = 1; bus.alloc_fl_ptr = fl_ptr_t'(fl); bus.alloc_rob_idx = rob_idx_t'($urandom);
      tick(); idle();
   endtask

   task automatic test_reset();
      #1;
      tests++; if (bus.alloc_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %0b exp 1", bus.alloc_ready); end
      tests++; if (bus.ckpt_count !== '0) begin fails++; $display("FAIL reset_count got %0d exp 0", bus.ckpt_count); end
      tests++; if (bus.flush_by_branch !== 1'b0) begin fails++; $display("FAIL reset_flush got %0b exp 0", bus.flush_by_branch); end
      tests++; if (bus.free_list_rd_ptr_out !== '0 || bus.flush_rob_idx !== '0) begin fails++; $display("FAIL reset_restore got %0d/%0d exp 0/0", bus.free_list_rd_ptr_out, bus.flush_rob_idx); end
      tests++; if (bus.perf_mispredicts !== '0 || bus.perf_full_stalls !== '0) begin fails++; $display("FAIL reset_perf got %0d/%0d exp 0/0", bus.perf_mispredicts, bus.perf_full_stalls); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         bus.alloc_valid = 1; bus.alloc_fl_ptr = fl_ptr_t'(5 + i); bus.alloc_rob_idx = rob_idx_t'(i + 10); #1;
         tests++; if (bus.alloc_ready !== 1'b1 || int'(bus.alloc_id) != i) begin fails++; $display("FAIL fill_id%0d got rdy=%0b id=%0d exp rdy=1 id=%0d", i, bus.alloc_ready, bus.alloc_id, i); end
         tick();
      end
      idle(); #1;
      tests++; if (bus.ckpt_count !== 3'd4 || bus.alloc_ready !== 1'b0) begin fails++; $display("FAIL fill_full got cnt=%0d rdy=%0b exp cnt=4 rdy=0", bus.ckpt_count, bus.alloc_ready); end
      bus.alloc_valid = 1; bus.alloc_fl_ptr = 9;
      repeat (3) tick();
      idle(); #1;
      tests++; if (bus.perf_full_stalls !== 32'(perf_exp(3)) || m_stall != 3) begin fails++; $display("FAIL fill_stalls got %0d exp %0d", bus.perf_full_stalls, perf_exp(3)); end
      tests++; if (bus.ckpt_count !== ckpt_ptr_t'(m_q.size())) begin fails++; $display("FAIL fill_hold got %0d exp %0d", bus.ckpt_count, m_q.size()); end
   endtask

   task automatic test_mispredict();
      bus.resolve_valid = 1; bus.resolve_id = 1; bus.resolve_mispredict = 1;
      tick(); idle(); #1;
      tests++; if (bus.flush_by_branch !== 1'b1 || bus.free_list_rd_ptr_out !== fl_ptr_t'(6)) begin fails++; $display("FAIL mis_pulse got flush=%0b ptr=%0d exp flush=1 ptr=6", bus.flush_by_branch, bus.free_list_rd_ptr_out); end
      tests++; if (bus.flush_rob_idx !== rob_idx_t'(11)) begin fails++; $display("FAIL mis_rob got %0d exp 11", bus.flush_rob_idx); end
      tick(); #1;
      tests++; if (bus.flush_by_branch !== 1'b0) begin fails++; $display("FAIL mis_one_cycle got %0b exp 0", bus.flush_by_branch); end
      tests++; if (bus.ckpt_count !== 3'd1 || bus.alloc_id !== ckpt_id_t'(1)) begin fails++; $display("FAIL mis_trunc got cnt=%0d id=%0d exp cnt=1 id=1", bus.ckpt_count, bus.alloc_id); end
      tests++; if (bus.perf_mispredicts !== 32'(perf_exp(m_mis))) begin fails++; $display("FAIL mis_perf got %0d exp %0d", bus.perf_mispredicts, perf_exp(m_mis)); end
   endtask

   task automatic test_inorder_pop();
      do_alloc(20);
      bus.resolve_valid = 1; bus.resolve_id = 1; tick(); idle(); tick(); #1;
      tests++; if (bus.ckpt_count !== 3'd2) begin fails++; $display("FAIL pop_blocked got %0d exp 2", bus.ckpt_count); end
      bus.resolve_valid = 1; bus.resolve_id = 0; tick(); idle(); #1;
      tests++; if (bus.ckpt_count !== ckpt_ptr_t'(m_q.size())) begin fails++; $display("FAIL pop_lat got %0d exp %0d", bus.ckpt_count, m_q.size()); end
      tick(); #1;
      tests++; if (bus.ckpt_count !== 3'd1) begin fails++; $display("FAIL pop_first got %0d exp 1", bus.ckpt_count); end
      tick(); #1;
      tests++; if (bus.ckpt_count !== 3'd0 || bus.alloc_id !== ckpt_id_t'(2)) begin fails++; $display("FAIL pop_second got cnt=%0d id=%0d exp cnt=0 id=2", bus.ckpt_count, bus.alloc_id); end
   endtask

   task automatic test_mis_pop();
      do_alloc(30); do_alloc(31); do_alloc(32);             // ids 2,3,0
      bus.resolve_valid = 1; bus.resolve_id = 2; tick();    // head resolved
      bus.resolve_id = 0; bus.resolve_mispredict = 1;
      bus.alloc_valid = 1; bus.alloc_fl_ptr = 33; #1;
      tests++; if (bus.alloc_ready !== 1'b1) begin fails++; $display("FAIL mpop_ready got %0b exp 1", bus.alloc_ready); end
      tick(); idle(); #1;
      tests++; if (bus.ckpt_count !== 3'd1 || bus.alloc_id !== ckpt_id_t'(0)) begin fails++; $display("FAIL mpop_count got cnt=%0d id=%0d exp cnt=1 id=0", bus.ckpt_count, bus.alloc_id); end
      tests++; if (bus.flush_by_branch !== 1'b1 || bus.free_list_rd_ptr_out !== fl_ptr_t'(32)) begin fails++; $display("FAIL mpop_restore got flush=%0b ptr=%0d exp 1/32", bus.flush_by_branch, bus.free_list_rd_ptr_out); end
      bus.resolve_valid = 1; bus.resolve_id = 3; bus.resolve_mispredict = 1;   // mispredict on head
      tick(); idle(); #1;
      tests++; if (bus.ckpt_count !== 3'd0 || bus.free_list_rd_ptr_out !== fl_ptr_t'(31)) begin fails++; $display("FAIL mhead_empty got cnt=%0d ptr=%0d exp 0/31", bus.ckpt_count, bus.free_list_rd_ptr_out); end
      tick();
   endtask

   task automatic test_rob_flush();
      do_alloc(40); do_alloc(41); do_alloc(42);
      bus.rob_flush = 1; bus.resolve_valid = 1; bus.resolve_id = m_q[1].id[CKPT_ID_W-1:0];
      bus.resolve_mispredict = 1; bus.alloc_valid = 1; #1;
      tests++; if (bus.alloc_ready !== 1'b0) begin fails++; $display("FAIL rflush_ready got %0b exp 0", bus.alloc_ready); end
      tick(); idle(); #1;
      tests++; if (bus.ckpt_count !== 3'd0 || bus.alloc_id !== ckpt_id_t'(0)) begin fails++; $display("FAIL rflush_clear got cnt=%0d id=%0d exp 0/0", bus.ckpt_count, bus.alloc_id); end
      tests++; if (bus.flush_by_branch !== 1'b0) begin fails++; $display("FAIL rflush_nopulse got %0b exp 0", bus.flush_by_branch); end
      tests++; if (bus.perf_mispredicts !== 32'(perf_exp(m_mis)) || bus.perf_full_stalls !== 32'(perf_exp(m_stall))) begin fails++; $display("FAIL rflush_perf got %0d/%0d exp %0d/%0d", bus.perf_mispredicts, bus.perf_full_stalls, perf_exp(m_mis), perf_exp(m_stall)); end
   endtask

   task automatic test_random();
      int bad = 0;
      for (int c = 0; c < 500; c++) begin
         idle();
         bus.rob_flush = ($urandom % 40) == 0;
         bus.alloc_valid = $urandom % 2;
         bus.alloc_fl_ptr = fl_ptr_t'($urandom); bus.alloc_rob_idx = rob_idx_t'($urandom);
         if (m_q.size() > 0 && ($urandom % 3) == 0) begin
            bus.resolve_valid = 1;
            bus.resolve_id = ckpt_id_t'(m_q[$urandom_range(0, m_q.size() - 1)].id);
            bus.resolve_mispredict = ($urandom % 4) == 0;
         end
         #1;
         tests++;
         if (bus.alloc_ready !== m_ready() || bus.alloc_id !== ckpt_id_t'(m_alloc_id()) ||
             bus.ckpt_count !== ckpt_ptr_t'(m_q.size()) || bus.flush_by_branch !== m_flush ||
             bus.free_list_rd_ptr_out !== fl_ptr_t'(m_flp) || bus.flush_rob_idx !== rob_idx_t'(m_frob) ||
             bus.perf_mispredicts !== 32'(perf_exp(m_mis)) || bus.perf_full_stalls !== 32'(perf_exp(m_stall))) begin
            fails++; bad++;
            if (bad < 10)
               $display("FAIL rand_c%0d got rdy=%0b id=%0d cnt=%0d fl=%0b ptr=%0d rob=%0d pm=%0d ps=%0d exp rdy=%0b id=%0d cnt=%0d fl=%0b ptr=%0d rob=%0d pm=%0d ps=%0d",
                        c, bus.alloc_ready, bus.alloc_id, bus.ckpt_count, bus.flush_by_branch, bus.free_list_rd_ptr_out,
                        bus.flush_rob_idx, bus.perf_mispredicts, bus.perf_full_stalls, m_ready(), m_alloc_id(), m_q.size(),
                        m_flush, m_flp, m_frob, perf_exp(m_mis), perf_exp(m_stall));
         end
         tick();
      end
      idle(); tick();
   endtask

   task automatic test_async_reset();
      do_alloc(50); do_alloc(51);
      bus.alloc_valid = 1; bus.alloc_fl_ptr = 52;
      #2 rst_n = 0; #1;   // mid-cycle, no clock edge
      tests++; if (bus.ckpt_count !== '0 || bus.alloc_ready !== 1'b1 || bus.alloc_id !== '0) begin fails++; $display("FAIL areset_state got cnt=%0d rdy=%0b id=%0d exp 0/1/0", bus.ckpt_count, bus.alloc_ready, bus.alloc_id); end
      tests++; if (bus.flush_by_branch !== 1'b0 || bus.free_list_rd_ptr_out !== '0 || bus.perf_mispredicts !== '0 || bus.perf_full_stalls !== '0) begin fails++; $display("FAIL areset_outs got fl=%0b ptr=%0d pm=%0d ps=%0d exp 0", bus.flush_by_branch, bus.free_list_rd_ptr_out, bus.perf_mispredicts, bus.perf_full_stalls); end
      idle();
      @(negedge clk); rst_n = 1; model_reset();
      @(posedge clk); #1;
      do_alloc(60); #1;
      tests++; if (bus.ckpt_count !== 3'd1 || bus.alloc_id !== ckpt_id_t'(1)) begin fails++; $display("FAIL areset_resume got cnt=%0d id=%0d exp 1/1", bus.ckpt_count, bus.alloc_id); end
   endtask

   initial begin
      rst_n = 0; idle(); model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      test_reset();
      test_fill();
      test_mispredict();
      test_inorder_pop();
      test_mis_pop();
      test_rob_flush();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
